memory_arbiter: RTL and testbench
=================================

Name: memory_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the single-port synchronous `memory` block (parameters DATA_LENGTH, MEM_SIZE).
- Accepts read/write requests on two valid/ready ports and serialises them onto the memory's wen/addr/din pins.
- Handles the memory's one-cycle registered read latency and returns a per-port response pulse with read data.
- Sits between two client masters (e.g. CPU load/store unit and a DMA/loader) and one memory instance.

Parameters:
- DATA_LENGTH, 8, data word width; must match the memory instance.
- MEM_SIZE, 1024, memory depth in words.
- ADDR_W is a localparam equal to $clog2(MEM_SIZE); it is not overridable.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid_0  input  1  port 0 request valid
- req_ready_0  output  1  port 0 request accepted this cycle
- req_we_0  input  1  port 0: 1 = write, 0 = read
- req_addr_0  input  ADDR_W  port 0 word address
- req_wdata_0  input  DATA_LENGTH  port 0 write data
- rsp_valid_0  output  1  port 0 completion pulse (read or write)
- rsp_rdata_0  output  DATA_LENGTH  port 0 read data, valid when rsp_valid_0=1 for a read
- req_valid_1, req_ready_1, req_we_1, req_addr_1, req_wdata_1, rsp_valid_1, rsp_rdata_1  same as port 0, for port 1
- mem_wen  output  1  to memory wen
- mem_addr  output  ADDR_W  to memory addr
- mem_din  output  DATA_LENGTH  to memory din
- mem_dout  input  DATA_LENGTH  from memory dout; registered, valid the cycle after addr is presented
- busy  output  1  high whenever state is not IDLE

Behaviour:

Reset (rst_n=0, asynchronous, also mid-operation):
- State goes to IDLE; priority pointer selects port 0.
- mem_wen=0, mem_addr=0, mem_din=0.
- rsp_valid_0/1=0, rsp_rdata_0/1=0, busy=0.
- Any in-flight operation is dropped with no response. A write that was in ISSUE may or may not have committed.

State machine: IDLE -> ISSUE -> (READ) -> IDLE.

IDLE:
- req_ready_x is combinational: asserted for exactly one port, the one granted among the valid ports.
- Only one valid: that port is granted.
- Both valid: the port selected by the priority pointer is granted.
- On grant (valid & ready at the edge): latch port id, we, addr and wdata; toggle the priority pointer to the other port; go to ISSUE.
- No valid: stay in IDLE, both ready=0.

ISSUE:
- mem_addr=latched addr, mem_din=latched wdata, mem_wen=latched we (mem_wen is high only in this state).
- Write: at end of cycle pulse rsp_valid_g for 1 cycle (registered); go to IDLE.
- Read: go to READ.

READ:
- mem_dout is now valid for the latched address.
- At end of cycle register mem_dout into rsp_rdata_g and pulse rsp_valid_g for 1 cycle; go to IDLE.
- mem_wen=0.

Latency from the accept edge:
- Write completes with rsp_valid 2 cycles later.
- Read completes with rsp_valid 3 cycles later.
- The rsp_valid cycle coincides with IDLE, so a new request may be accepted in that same cycle.
- Peak throughput: one write per 2 cycles, one read per 3 cycles.

Other rules:
- Requester rule: while valid & !ready, hold we/addr/wdata stable. The arbiter samples only on accept.
- rsp_rdata_x holds its value until the next read completion on that port. A write response leaves rsp_rdata unchanged.
- rsp_valid_0 and rsp_valid_1 are never high in the same cycle.
- Outside ISSUE, mem_addr and mem_din hold their last driven values.
- Round-robin is fair: with both ports continuously valid, grants strictly alternate 0,1,0,1...
- An idle cycle does not change the priority pointer.
- Address range is 0..MEM_SIZE-1. No wrap or bounds logic is needed because ADDR_W covers it exactly.

Test Plan:
- Reset then single write: port 0 writes addr 10, data 8'hA5. mem_wen=1 with mem_addr=10 for exactly one cycle; rsp_valid_0 pulses 2 cycles after accept; port 1 ready stays 0.
- Read-back: port 1 reads addr 10 after the test above. rsp_valid_1 pulses 3 cycles after accept with rsp_rdata_1=8'hA5; rsp_rdata_0 is unchanged.
- Contention: both ports valid continuously from reset, port 0 writing addr 20 = 8'h3C and port 1 reading addr 20. Port 0 is granted first, then port 1; port 1 reads 8'h3C; with continued valids, grants alternate 0,1,0,1.
- Back-to-back: port 0 issues 4 writes to addrs 0..3 (8'h11..8'h44) with valid held high. An accept occurs every 2 cycles; reading 0..3 back returns 8'h11..8'h44.
- Reset mid-read: assert rst_n=0 during READ. busy, rsp_valid_x and mem_wen go to 0 immediately with no response pulse after release; the next contended request is granted to port 0.
- Idle/unknown-free: no requests for 20 cycles after reset. mem_wen stays 0, busy stays 0, req_ready_x stay 0.

Source files
------------

// File: rtl/memory_arbiter.sv
// Two-port round-robin arbiter that serialises read/write requests onto a single-port
// synchronous memory and returns one response pulse per request, absorbing the read latency.
module memory_arbiter #(
  parameter  int DATA_LENGTH = 8,
  parameter  int MEM_SIZE    = 1024,
  localparam int ADDR_W      = $clog2(MEM_SIZE)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid_0,
  output logic                   req_ready_0,
  input  logic                   req_we_0,
  input  logic [ADDR_W-1:0]      req_addr_0,
  input  logic [DATA_LENGTH-1:0] req_wdata_0,
  output logic                   rsp_valid_0,
  output logic [DATA_LENGTH-1:0] rsp_rdata_0,
  input  logic                   req_valid_1,
  output logic                   req_ready_1,
  input  logic                   req_we_1,
  input  logic [ADDR_W-1:0]      req_addr_1,
  input  logic [DATA_LENGTH-1:0] req_wdata_1,
  output logic                   rsp_valid_1,
  output logic [DATA_LENGTH-1:0] rsp_rdata_1,
  output logic                   mem_wen,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_LENGTH-1:0] mem_din,
  input  logic [DATA_LENGTH-1:0] mem_dout,
  output logic                   busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;

  logic [1:0]             state_reg;
  logic                   prio_reg;    // port preferred when both are valid
  logic                   gnt_id_reg;
  logic                   we_reg;
  logic [ADDR_W-1:0]      addr_reg;
  logic [DATA_LENGTH-1:0] wdata_reg;
  logic                   rsp_valid_0_reg;
  logic                   rsp_valid_1_reg;
  logic [DATA_LENGTH-1:0] rsp_rdata_0_reg;
  logic [DATA_LENGTH-1:0] rsp_rdata_1_reg;

  logic idle;
  logic grant_0;
  logic grant_1;
  logic accept;
  logic rsp_fire;

  assign idle    = (state_reg == IDLE);
  assign grant_1 = req_valid_1 & (~req_valid_0 | prio_reg);
  assign grant_0 = req_valid_0 & ~grant_1;
  assign accept  = idle & (req_valid_0 | req_valid_1);

  assign req_ready_0 = idle & grant_0;
  assign req_ready_1 = idle & grant_1;

  // Latched request drives the memory pins directly, so they hold between operations.
  assign mem_addr = addr_reg;
  assign mem_din  = wdata_reg;
  assign mem_wen  = (state_reg == ISSUE) & we_reg;
  assign busy     = ~idle;

  assign rsp_fire = ((state_reg == ISSUE) & we_reg) | (state_reg == READ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      prio_reg   <= 1'b0;
      gnt_id_reg <= 1'b0;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            gnt_id_reg <= grant_1;
            we_reg     <= grant_1 ? req_we_1    : req_we_0;
            addr_reg   <= grant_1 ? req_addr_1  : req_addr_0;
            wdata_reg  <= grant_1 ? req_wdata_1 : req_wdata_0;
            prio_reg   <= ~grant_1;
            state_reg  <= ISSUE;
          end
        end
        ISSUE:   state_reg <= we_reg ? IDLE : READ;
        READ:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_0_reg <= 1'b0;
      rsp_valid_1_reg <= 1'b0;
      rsp_rdata_0_reg <= '0;
      rsp_rdata_1_reg <= '0;
    end else begin
      rsp_valid_0_reg <= rsp_fire & ~gnt_id_reg;
      rsp_valid_1_reg <= rsp_fire & gnt_id_reg;
      // mem_dout is valid for the latched address only during READ
      if (state_reg == READ) begin
        if (gnt_id_reg) rsp_rdata_1_reg <= mem_dout;
        else            rsp_rdata_0_reg <= mem_dout;
      end
    end
  end

  assign rsp_valid_0 = rsp_valid_0_reg;
  assign rsp_valid_1 = rsp_valid_1_reg;
  assign rsp_rdata_0 = rsp_rdata_0_reg;
  assign rsp_rdata_1 = rsp_rdata_1_reg;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed table, hand sequences for contention
// and reset, then random traffic against a transaction-level reference model.
module tb_memory_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid_0, req_ready_0, req_we_0, rsp_valid_0;
  logic [9:0] req_addr_0;
  logic [7:0] req_wdata_0, rsp_rdata_0;
  logic       req_valid_1, req_ready_1, req_we_1, rsp_valid_1;
  logic [9:0] req_addr_1;
  logic [7:0] req_wdata_1, rsp_rdata_1;
  logic       mem_wen, busy;
  logic [9:0] mem_addr;
  logic [7:0] mem_din, mem_dout;

  int n_vec  = 0;
  int n_miss = 0;
  logic [7:0] exp_rd [2];
  logic [7:0] mem_arr [0:1023];
  logic [7:0] ref_mem [0:1023];

  always #5 clk = ~clk;

  memory_arbiter #(.DATA_LENGTH(8), .MEM_SIZE(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_we_0(req_we_0),
    .req_addr_0(req_addr_0), .req_wdata_0(req_wdata_0),
    .rsp_valid_0(rsp_valid_0), .rsp_rdata_0(rsp_rdata_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_we_1(req_we_1),
    .req_addr_1(req_addr_1), .req_wdata_1(req_wdata_1),
    .rsp_valid_1(rsp_valid_1), .rsp_rdata_1(rsp_rdata_1),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy)
  );

  // Single-port synchronous memory with registered read data
  always @(posedge clk) begin
    if (mem_wen) mem_arr[mem_addr] <= mem_din;
    mem_dout <= mem_arr[mem_addr];
  end

  typedef struct {
    int         port;
    logic       we;
    logic [9:0] addr;
    logic [7:0] wdata;
    int         exp_lat;
    logic [7:0] exp_rdata;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic v, input logic we, input logic [9:0] a,
                       input logic [7:0] d);
    if (p == 0) begin
      req_valid_0 = v; req_we_0 = we; req_addr_0 = a; req_wdata_0 = d;
    end else begin
      req_valid_1 = v; req_we_1 = we; req_addr_1 = a; req_wdata_1 = d;
    end
  endtask

  function automatic logic rdy(input int p);
    return (p == 0) ? req_ready_0 : req_ready_1;
  endfunction

  function automatic logic rv(input int p);
    return (p == 0) ? rsp_valid_0 : rsp_valid_1;
  endfunction

  function automatic logic [7:0] rd(input int p);
    return (p == 0) ? rsp_rdata_0 : rsp_rdata_1;
  endfunction

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
  endtask

  // One isolated request; called with the arbiter idle, returns in the response cycle.
  task automatic run_txn(input vec_t v);
    int lat;
    logic got;
    int o;
    o = 1 - v.port;
    drive(v.port, 1'b1, v.we, v.addr, v.wdata);
    #1;
    check("ready_granted", rdy(v.port), 1'b1);
    check("ready_other", rdy(o), 1'b0);
    tick();
    drive(v.port, 1'b0, 1'b0, 10'd0, 8'd0);
    check("issue_wen", mem_wen, v.we);
    check("issue_addr", mem_addr, v.addr);
    if (v.we) check("issue_din", mem_din, v.wdata);
    lat = 1;
    got = 1'b0;
    while (!got && lat < 8) begin
      if (rv(v.port)) got = 1'b1;
      else begin
        tick();
        lat++;
      end
    end
    check("rsp_latency", lat, v.exp_lat);
    check("rsp_valid_other", rv(o), 1'b0);
    if (!v.we) begin
      check("rsp_rdata", rd(v.port), v.exp_rdata);
      exp_rd[v.port] = v.exp_rdata;
    end else begin
      check("rsp_rdata_hold", rd(v.port), exp_rd[v.port]);
    end
    check("rsp_rdata_other", rd(o), exp_rd[o]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [8];
    vec_t v;
    int acc_cyc [4];
    int k, c, nrd, w;
    int q [$];

    for (int i = 0; i < 1024; i++) begin
      mem_arr[i] = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 10'd0, 8'd0);
    drive(1, 1'b0, 1'b0, 10'd0, 8'd0);
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
    repeat (3) tick();

    // Reset state
    check("rst_busy", busy, 1'b0);
    check("rst_wen", mem_wen, 1'b0);
    check("rst_addr", mem_addr, 10'd0);
    check("rst_din", mem_din, 8'd0);
    check("rst_rsp_valid", {rsp_valid_1, rsp_valid_0}, 2'b00);
    check("rst_rdata", {rsp_rdata_1, rsp_rdata_0}, 16'h0000);
    rst_n = 1'b1;

    // Idle: nothing moves without requests
    repeat (20) begin
      tick();
      check("idle_outputs", {mem_wen, busy, req_ready_0, req_ready_1}, 4'b0000);
    end

    // Directed table of isolated transactions
    tbl[0] = '{0, 1'b1, 10'd10, 8'hA5, 2, 8'h00};
    tbl[1] = '{1, 1'b0, 10'd10, 8'h00, 3, 8'hA5};
    tbl[2] = '{1, 1'b1, 10'd5,  8'hC3, 2, 8'h00};
    tbl[3] = '{0, 1'b0, 10'd5,  8'h00, 3, 8'hC3};
    tbl[4] = '{0, 1'b1, 10'd6,  8'h7E, 2, 8'h00};
    tbl[5] = '{1, 1'b0, 10'd6,  8'h00, 3, 8'h7E};
    tbl[6] = '{0, 1'b0, 10'd10, 8'h00, 3, 8'hA5};
    tbl[7] = '{1, 1'b0, 10'd9,  8'h00, 3, 8'h53};
    for (int i = 0; i < 8; i++) run_txn(tbl[i]);

    // Back-to-back writes with valid held: one accept every 2 cycles
    k = 0;
    c = 0;
    for (int i = 0; i < 4; i++) acc_cyc[i] = 0;
    drive(0, 1'b1, 1'b1, 10'd0, 8'h11);
    while (k < 4 && c < 40) begin
      #1;
      w = 0;
      if (req_ready_0) begin
        acc_cyc[k] = c;
        k++;
        w = 1;
      end
      tick();
      c++;
      if (w == 1) begin
        if (k < 4) drive(0, 1'b1, 1'b1, 10'(k), 8'((k + 1) * 17));
        else       drive(0, 1'b0, 1'b0, 10'd0, 8'd0);
      end
    end
    drive(0, 1'b0, 1'b0, 10'd0, 8'd0);
    check("b2b_accepts", k, 4);
    for (int i = 1; i < 4; i++) check("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 2);
    tick();
    for (int i = 0; i < 4; i++) begin
      v = '{1, 1'b0, 10'(i), 8'h00, 3, 8'((i + 1) * 17)};
      run_txn(v);
    end

    // Contention from reset: grants alternate, port 1 sees port 0's write
    pulse_reset();
    drive(0, 1'b1, 1'b1, 10'd20, 8'h3C);
    drive(1, 1'b1, 1'b0, 10'd20, 8'h00);
    nrd = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      check("cont_ready_onehot", req_ready_0 & req_ready_1, 1'b0);
      check("cont_rsp_onehot", rsp_valid_0 & rsp_valid_1, 1'b0);
      if (req_ready_0) q.push_back(0);
      if (req_ready_1) q.push_back(1);
      if (rsp_valid_1) begin
        check("cont_rdata", rsp_rdata_1, 8'h3C);
        nrd++;
      end
      tick();
    end
    drive(0, 1'b0, 1'b0, 10'd0, 8'd0);
    drive(1, 1'b0, 1'b0, 10'd0, 8'd0);
    check("cont_grant_count", (q.size() >= 5) ? 1 : 0, 1);
    for (int i = 0; i < q.size(); i++) check("cont_grant_order", q[i], i % 2);
    check("cont_read_seen", (nrd >= 1) ? 1 : 0, 1);
    c = 0;
    while (busy && c < 5) begin
      tick();
      c++;
    end
    check("cont_drain", busy, 1'b0);

    // Reset during READ: no response, pointer back to port 0
    pulse_reset();
    drive(0, 1'b1, 1'b0, 10'd64, 8'h00);
    tick();
    drive(0, 1'b0, 1'b0, 10'd0, 8'd0);
    tick();
    check("mid_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_busy", busy, 1'b0);
    check("mid_rsp_valid", {rsp_valid_1, rsp_valid_0}, 2'b00);
    check("mid_wen", mem_wen, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (5) begin
      tick();
      check("mid_no_rsp", {rsp_valid_1, rsp_valid_0}, 2'b00);
    end
    check("mid_rdata0", rsp_rdata_0, 8'h00);
    drive(0, 1'b1, 1'b1, 10'd200, 8'hE1);
    drive(1, 1'b1, 1'b1, 10'd201, 8'hE2);
    #1;
    check("mid_regrant_0", req_ready_0, 1'b1);
    check("mid_regrant_1", req_ready_1, 1'b0);
    tick();
    drive(0, 1'b0, 1'b0, 10'd0, 8'd0);
    drive(1, 1'b0, 1'b0, 10'd0, 8'd0);
    tick();

    // Random traffic against a transaction-level model
    pulse_reset();
    begin
      logic       pend [2];
      logic       p_we [2];
      logic [9:0] p_addr [2];
      logic [7:0] p_data [2];
      int ptr, free_at, rsp_at, rsp_port, iss_at, g, lat;
      logic       rsp_read, iss_we;
      logic [7:0] rsp_data;
      logic [9:0] iss_addr;
      logic [7:0] iss_din;
      ptr = 0; free_at = 0; rsp_at = -1; rsp_port = 0; iss_at = -1;
      rsp_read = 1'b0; rsp_data = 8'h00; iss_we = 1'b0; iss_addr = 10'd0; iss_din = 8'd0;
      for (int p = 0; p < 2; p++) begin
        pend[p] = 1'b0; p_we[p] = 1'b0; p_addr[p] = 10'd0; p_data[p] = 8'd0;
      end
      for (int rc = 0; rc < 1500; rc++) begin
        for (int p = 0; p < 2; p++) begin
          if (!pend[p] && $urandom_range(0, 99) < 40) begin
            pend[p]   = 1'b1;
            p_we[p]   = 1'($urandom_range(0, 1));
            p_addr[p] = 10'(64 + $urandom_range(0, 63));
            p_data[p] = 8'($urandom);
          end
          drive(p, pend[p], p_we[p], p_addr[p], p_data[p]);
        end
        #1;
        if (rsp_at == rc && rsp_read) exp_rd[rsp_port] = rsp_data;
        g = -1;
        if (rc >= free_at) begin
          if (pend[0] && pend[1]) g = ptr;
          else if (pend[0])       g = 0;
          else if (pend[1])       g = 1;
        end
        check("rnd_ready_0", req_ready_0, (g == 0) ? 1'b1 : 1'b0);
        check("rnd_ready_1", req_ready_1, (g == 1) ? 1'b1 : 1'b0);
        check("rnd_rsp_valid_0", rsp_valid_0, (rsp_at == rc && rsp_port == 0) ? 1'b1 : 1'b0);
        check("rnd_rsp_valid_1", rsp_valid_1, (rsp_at == rc && rsp_port == 1) ? 1'b1 : 1'b0);
        check("rnd_rdata_0", rsp_rdata_0, exp_rd[0]);
        check("rnd_rdata_1", rsp_rdata_1, exp_rd[1]);
        check("rnd_busy", busy, (rc < free_at) ? 1'b1 : 1'b0);
        check("rnd_wen", mem_wen, (iss_at == rc && iss_we) ? 1'b1 : 1'b0);
        if (iss_at == rc) begin
          check("rnd_mem_addr", mem_addr, iss_addr);
          if (iss_we) check("rnd_mem_din", mem_din, iss_din);
        end
        if (g >= 0) begin
          lat      = p_we[g] ? 2 : 3;
          free_at  = rc + lat;
          rsp_at   = rc + lat;
          rsp_port = g;
          rsp_read = !p_we[g];
          iss_at   = rc + 1;
          iss_we   = p_we[g];
          iss_addr = p_addr[g];
          iss_din  = p_data[g];
          if (p_we[g]) ref_mem[p_addr[g]] = p_data[g];
          else         rsp_data = ref_mem[p_addr[g]];
          ptr     = 1 - g;
          pend[g] = 1'b0;
        end
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
